// File: rtl/battleship_pkg.sv
// Shared battleship types and constants: mode encoding, mode FSM states and
// the default button debounce length.
package battleship_pkg;

    localparam logic MODE_PLACE  = 1'b0;
    localparam logic MODE_ATTACK = 1'b1;

    // 1 ms at 50 MHz
    localparam int DEBOUNCE_DEFAULT = 50000;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } modesel_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus counting debouncer for an active-low push-button.
// Outputs the debounced level (active-high) and a one-cycle press strobe.
module button_debouncer
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             stable;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;

    // Synchronizer stage: both flops idle at the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= btn_n;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce stage: any sample equal to stable restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            stable_prev <= stable;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = ~stable;
    assign press = stable_prev & ~stable;

endmodule

// File: rtl/mode_selector.sv
// Mode push-button to registered mode bit: debounces BTN and toggles MODE once
// per press unless BUSY. Define MODESEL_DEFER_EN to defer busy presses instead.
module mode_selector
    import battleship_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    input  logic BUSY,
    output logic MODE,
    output logic MODE_PULSE,
    output logic DENIED,
    output logic PRESSED
);

    logic press;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (CLK),
        .rst   (RST),
        .btn_n (BTN),
        .level (PRESSED),
        .press (press)
    );

`ifdef MODESEL_DEFER_EN
    modesel_state_e state;
`endif

    // Mode FSM stage: strobes default low, at most one toggle is ever owed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            MODE       <= MODE_PLACE;
            MODE_PULSE <= 1'b0;
            DENIED     <= 1'b0;
`ifdef MODESEL_DEFER_EN
            state      <= IDLE;
`endif
        end else begin
            MODE_PULSE <= 1'b0;
            DENIED     <= 1'b0;
`ifdef MODESEL_DEFER_EN
            case (state)
                IDLE: begin
                    if (press) begin
                        if (BUSY) begin
                            DENIED <= 1'b1;
                            state  <= PENDING;
                        end else begin
                            MODE       <= ~MODE;
                            MODE_PULSE <= 1'b1;
                        end
                    end
                end
                PENDING: begin
                    if (!BUSY) begin
                        MODE       <= ~MODE;
                        MODE_PULSE <= 1'b1;
                        state      <= IDLE;
                    end else if (press) begin
                        DENIED <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
`else
            if (press) begin
                if (BUSY) begin
                    DENIED <= 1'b1;
                end else begin
                    MODE       <= ~MODE;
                    MODE_PULSE <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_mode_selector.sv
// Scoreboard bench for mode_selector with DEBOUNCE_CYCLES = 4; expected strobe
// events are queued by the stimulus and matched by a negedge monitor.
module tb_mode_selector;

    localparam int DC = 4;

    logic CLK = 1'b0;
    logic RST;
    logic BTN;
    logic BUSY;
    logic MODE;
    logic MODE_PULSE;
    logic DENIED;
    logic PRESSED;

    mode_selector #(.DEBOUNCE_CYCLES(DC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BTN        (BTN),
        .BUSY       (BUSY),
        .MODE       (MODE),
        .MODE_PULSE (MODE_PULSE),
        .DENIED     (DENIED),
        .PRESSED    (PRESSED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit pulse;
        bit denied;
        bit mode;
        int at;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  e0;
    bit  exp_mode;

    always @(posedge CLK) cyc <= cyc + 1;

    // Every strobe must match the oldest queued expectation, value and cycle.
    always @(negedge CLK) begin
        if (MODE_PULSE === 1'b1 || DENIED === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: pulse=%0b denied=%0b mode=%0b at cycle %0d, required none",
                         MODE_PULSE, DENIED, MODE, cyc);
            end else begin
                mon_e = q.pop_front();
                if ({MODE_PULSE, DENIED, MODE} !== {mon_e.pulse, mon_e.denied, mon_e.mode} || cyc != mon_e.at) begin
                    fails++;
                    $display("FAIL event: got pulse=%0b denied=%0b mode=%0b cycle %0d, required pulse=%0b denied=%0b mode=%0b cycle %0d",
                             MODE_PULSE, DENIED, MODE, cyc, mon_e.pulse, mon_e.denied, mon_e.mode, mon_e.at);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic expect_toggle(input int at);
        exp_mode = ~exp_mode;
        q.push_back('{1'b1, 1'b0, exp_mode, at});
    endtask

    task automatic expect_deny(input int at);
        q.push_back('{1'b0, 1'b1, exp_mode, at});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mode"},  MODE,       1'b0);
        check({tag, "_pulse"}, MODE_PULSE, 1'b0);
        check({tag, "_denied"}, DENIED,    1'b0);
        check({tag, "_pressed"}, PRESSED,  1'b0);
    endtask

    // Clean press held 8 cycles then released; event lands DC+2 edges after first low sample.
    task automatic press(input bit deny);
        int start;
        start = cyc + 1;
        if (deny) expect_deny(start + DC + 2);
        else      expect_toggle(start + DC + 2);
        BTN = 1'b0;
        step(8);
        BTN = 1'b1;
        step(8);
    endtask

    initial begin
        RST = 1'b1;
        BTN = 1'b1;
        BUSY = 1'b0;
        exp_mode = 1'b0;
        step(3);
        check_reset_outputs("reset");
        RST = 1'b0;

        // Idle button
        step(20);
        check("idle_mode", MODE, 1'b0);
        check("idle_pressed", PRESSED, 1'b0);

        // Clean press with exact debounce timing
        e0 = cyc + 1;
        expect_toggle(e0 + 6);
        BTN = 1'b0;
        step(5);
        check("press_edge4_pressed", PRESSED, 1'b0);
        step(1);
        check("press_edge5_pressed", PRESSED, 1'b1);
        step(4);
        BTN = 1'b1;
        step(5);
        check("release_edge4_pressed", PRESSED, 1'b1);
        step(1);
        check("release_edge5_pressed", PRESSED, 1'b0);
        step(5);
        check("first_toggle_mode", MODE, 1'b1);
        press(1'b0);
        check("second_toggle_mode", MODE, 1'b0);

        // Bouncing button never settles for DC samples
        for (int i = 0; i < 8; i++) begin
            BTN = 1'b0;
            step(2);
            BTN = 1'b1;
            step(2);
        end
        step(10);
        check("bounce_mode", MODE, exp_mode);
        check("bounce_pressed", PRESSED, 1'b0);

        // Press while busy
        BUSY = 1'b1;
        press(1'b1);
`ifdef MODESEL_DEFER_EN
        expect_toggle(cyc + 1);
`endif
        BUSY = 1'b0;
        step(3);
        check("busy_press_mode", MODE, exp_mode);
        step(5);

`ifdef MODESEL_DEFER_EN
        // Two busy presses owe only one toggle
        BUSY = 1'b1;
        press(1'b1);
        press(1'b1);
        expect_toggle(cyc + 1);
        BUSY = 1'b0;
        step(3);
        check("double_busy_mode", MODE, exp_mode);
        step(5);
`endif

        // Reset discards an owed toggle
        BUSY = 1'b1;
        press(1'b1);
        RST = 1'b1;
        step(2);
        exp_mode = 1'b0;
        check_reset_outputs("pending_rst");
        RST = 1'b0;
        BUSY = 1'b0;
        step(10);
        check("pending_rst_mode", MODE, 1'b0);

        // Reset mid-debounce with the button still held afterwards
        BTN = 1'b0;
        step(4);
        RST = 1'b1;
        step(2);
        check_reset_outputs("debounce_rst");
        RST = 1'b0;
        e0 = cyc + 1;
        expect_toggle(e0 + 6);
        step(10);
        check("held_rst_mode", MODE, 1'b1);
        check("held_rst_pressed", PRESSED, 1'b1);
        BTN = 1'b1;
        step(15);

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d outstanding, required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mode_selector.md
# mode_selector

Input-side counterpart of the battleship mode display path: converts the raw, active-low, bouncing mode push-button into the registered mode bit that drives the mode 7-segment decoder's `A` input. Synchronizes and debounces the button and toggles the mode once per confirmed press. Blocks mode changes while the game logic reports a move in progress. One instance sits between the board button pin and the mode decoder.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples required to accept a button level change (1 ms at 50 MHz); legal range ≥ 2.
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `BTN` in 1: raw mode button, asynchronous, active-low (0 = pressed).
- `BUSY` in 1: game logic mid-move; mode change not permitted while 1.
- `MODE` out 1: current mode (0 = placement, 1 = attack); feeds the decoder `A`.
- `MODE_PULSE` out 1: one-cycle strobe in the cycle `MODE` takes a new value.
- `DENIED` out 1: one-cycle strobe when a confirmed press arrives while `BUSY` = 1.
- `PRESSED` out 1: debounced button level, active-high (1 = held).

## Operation
- Synchronizer: two flops on `BTN`, both reset to 1 (released).
- Debouncer: `stable` register (reset 1) plus counter (reset 0, width `$clog2(DEBOUNCE_CYCLES)`). Each cycle the synchronized value differs from `stable`, the counter increments. When it differs with the counter at `DEBOUNCE_CYCLES-1`, `stable` takes the new value and the counter clears. Any cycle equal to `stable` clears the counter, so a glitch restarts the count. The counter never wraps.
- Press event: `stable` transition 1→0, detected one cycle after `stable` changes. Release produces no event. A new press requires a debounced release first.
- Mode FSM states: `IDLE` (no deferred press), `PENDING` (deferred press, macro builds only).
- `IDLE`, press, `BUSY`=0: `MODE` inverts, `MODE_PULSE`=1.
- `IDLE`, press, `BUSY`=1: `DENIED`=1, `MODE` unchanged. Without the macro the FSM stays in `IDLE`; with the macro it goes to `PENDING`.
- `PENDING`, `BUSY`=1: hold. Further presses assert `DENIED` again but do not stack; at most one toggle is owed.
- `PENDING`, `BUSY`=0: `MODE` inverts, `MODE_PULSE`=1, return to `IDLE`.
- `BUSY` is sampled in the same cycle as the press event.
- Reset values: `MODE`=0, `MODE_PULSE`=0, `DENIED`=0, `PRESSED`=0, FSM `IDLE`, counter 0.
- Reset mid-debounce or mid-`PENDING` discards all progress and any owed toggle.
- A button held through reset deassertion is debounced afresh and counts as one press.

## Timing
- `BTN` low and clean from the edge-0 sample: `PRESSED` rises after edge `DEBOUNCE_CYCLES+1`. `MODE`/`MODE_PULSE` update after edge `DEBOUNCE_CYCLES+2`.
- Release is symmetric: `PRESSED` falls `DEBOUNCE_CYCLES+1` edges after a clean high.
- Deferred toggle: `MODE` updates on the edge where `BUSY`=0 is first sampled in `PENDING`, one cycle of latency.
- `MODE_PULSE` and `DENIED` are never high in the same cycle.
- `MODE_PULSE` is never high on two consecutive cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `MODESEL_DEFER_EN` defined: a press during `BUSY` is remembered (`PENDING`) and applied when `BUSY` clears.
- `MODESEL_DEFER_EN` undefined: such a press is discarded after `DENIED`. The `PENDING` state and its register are not built.

## Structure
- Shared package `battleship_pkg` holds:
  - `MODE_PLACE` = 1'b0, `MODE_ATTACK` = 1'b1;
  - the FSM state encoding;
  - the default debounce constant.
- Sub-module `button_debouncer`, parameterized by `DEBOUNCE_CYCLES`: synchronizer, counter and `stable`; outputs the debounced level and the press strobe. It is reusable for the board's coordinate/fire buttons.
- `mode_selector` instantiates it and contains the mode FSM only.

## Test plan
(All scenarios use `DEBOUNCE_CYCLES`=4.)
- Reset, then `BTN`=1 for 20 cycles -> `MODE`=0 and `PRESSED`=0, with `MODE_PULSE`=0 and `DENIED`=0 throughout.
- `BTN` driven low at edge 0 and held, `BUSY`=0 -> `PRESSED`=1 after edge 5; `MODE` 0→1 with `MODE_PULSE`=1 for exactly one cycle after edge 6. A second clean press/release cycle returns `MODE` to 0.
- `BTN` toggling low/high every 2 cycles for 30 cycles, then held high -> no `MODE_PULSE`, `MODE` unchanged.
- Press with `BUSY`=1, `BUSY` dropped 10 cycles later:
  - without the macro -> `DENIED` once, `MODE` stays 0;
  - with `MODESEL_DEFER_EN` -> `DENIED` once, then `MODE`=1 one edge after `BUSY` falls.
- With the macro, two presses while `BUSY`=1, then `BUSY`=0 -> `DENIED` twice, exactly one toggle (`MODE`=1).
- `RST` asserted 2 cycles before a pending toggle or mid-debounce count -> all outputs at reset values, no toggle afterwards. `BTN` still held after reset -> exactly one toggle 6 edges after reset deassertion.
